paddle_ctrl: RTL and testbench

//   Upstream stage of the ball/physics block. Turns keyboard keycodes into

---
 rtl/paddle_ctrl.sv | 158 +++++++++++++++
 tb/tb_paddle_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_ctrl.sv
// Paddle position controller: keycodes -> clamped, accelerating paddle Y, one update per frame.
// Optional PADDLE_AI_EN macro replaces paddle 2 keyboard control with a ball-tracking CPU.
module paddle_ctrl #(
  parameter int P1_X         = 50,
  parameter int P2_X         = 580,
  parameter int CENTER_Y     = 240,
  parameter int Y_MIN        = 20,
  parameter int Y_MAX        = 461,
  parameter int HALF_LEN     = 30,
  parameter int HALF_W       = 4,
  parameter int STEP_MIN     = 2,
  parameter int STEP_MAX     = 8,
  parameter int ACCEL_FRAMES = 4,
  parameter int AI_STEP      = 4,
  parameter int AI_DEADBAND  = 6
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  input  logic       nGame,
  input  logic       eGame,
  input  logic [9:0] BallY,
  output logic [9:0] Paddle1X,
  output logic [9:0] Paddle1Y,
  output logic [9:0] Paddle2X,
  output logic [9:0] Paddle2Y,
  output logic [9:0] Paddle1L,
  output logic [9:0] Paddle1W,
  output logic [9:0] Paddle2L,
  output logic [9:0] Paddle2W,
  output logic       paddleHold
);

  localparam logic signed [10:0] Y_LO     = 11'(Y_MIN + HALF_LEN);
  localparam logic signed [10:0] Y_HI     = 11'(Y_MAX - HALF_LEN);
  localparam logic [9:0]         Y_HOME   = 10'(CENTER_Y);
  localparam logic [7:0]         SPD_MIN  = 8'(STEP_MIN);
  localparam logic [7:0]         SPD_MAX  = 8'(STEP_MAX);
  localparam logic [7:0]         CNT_LAST = 8'(ACCEL_FRAMES - 1);

  typedef enum logic {HOLD, PLAY} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

  state_t            state, state_n;
  logic [9:0]        pos_y   [2];
  logic [9:0]        pos_y_n [2];
  logic [7:0]        speed   [2];
  logic [7:0]        speed_n [2];
  logic [7:0]        count   [2];
  logic [7:0]        count_n [2];
  dir_t              last    [2];
  dir_t              last_n  [2];
  logic [1:0]        up_key, dn_key;
  dir_t              dir;
  logic [7:0]        step;
  logic signed [10:0] tgt;

  function automatic logic [9:0] clamp_y(input logic signed [10:0] v);
    if (v < Y_LO)      clamp_y = Y_LO[9:0];
    else if (v > Y_HI) clamp_y = Y_HI[9:0];
    else               clamp_y = v[9:0];
  endfunction

  assign up_key[0] = (keycode0 == 8'h1A) || (keycode1 == 8'h1A);
  assign dn_key[0] = (keycode0 == 8'h16) || (keycode1 == 8'h16);
  assign up_key[1] = (keycode0 == 8'h52) || (keycode1 == 8'h52);
  assign dn_key[1] = (keycode0 == 8'h51) || (keycode1 == 8'h51);

`ifdef PADDLE_AI_EN
  localparam logic signed [10:0] AI_S  = 11'(AI_STEP);
  localparam logic signed [10:0] AI_DB = 11'(AI_DEADBAND);
  logic signed [10:0] ball_s, p2_s;
  assign ball_s = $signed({1'b0, BallY});
  assign p2_s   = $signed({1'b0, pos_y[1]});
`else
  logic unused_ball;
  assign unused_ball = ^BallY;
`endif

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state <= HOLD;
      for (int i = 0; i < 2; i++) begin
        pos_y[i] <= Y_HOME;
        speed[i] <= SPD_MIN;
        count[i] <= '0;
        last[i]  <= DIR_NONE;
      end
    end else begin
      state <= state_n;
      for (int i = 0; i < 2; i++) begin
        pos_y[i] <= pos_y_n[i];
        speed[i] <= speed_n[i];
        count[i] <= count_n[i];
        last[i]  <= last_n[i];
      end
    end
  end

  // Either status flag forces HOLD (and a recentre on the same edge); both clear means PLAY.
  always_comb begin
    state_n = (nGame || eGame) ? HOLD : PLAY;
    dir  = DIR_NONE;
    step = SPD_MIN;
    tgt  = '0;
    for (int i = 0; i < 2; i++) begin
      pos_y_n[i] = Y_HOME;
      speed_n[i] = SPD_MIN;
      count_n[i] = '0;
      last_n[i]  = DIR_NONE;
    end
    if (state == PLAY && !nGame && !eGame) begin
      for (int i = 0; i < 2; i++) begin
        dir = (up_key[i] && !dn_key[i]) ? DIR_UP :
              (dn_key[i] && !up_key[i]) ? DIR_DOWN : DIR_NONE;
        pos_y_n[i] = pos_y[i];
        if (dir != DIR_NONE) begin
          last_n[i] = dir;
          if (dir != last[i]) begin
            step       = SPD_MIN;
            count_n[i] = 8'd1;
          end else begin
            step = speed[i];
            speed_n[i] = speed[i];
            if (count[i] == CNT_LAST) begin
              speed_n[i] = (speed[i] >= SPD_MAX) ? SPD_MAX : speed[i] + 8'd1;
            end else begin
              count_n[i] = count[i] + 8'd1;
            end
          end
          if (dir == DIR_UP) tgt = $signed({1'b0, pos_y[i]}) - $signed({3'b000, step});
          else               tgt = $signed({1'b0, pos_y[i]}) + $signed({3'b000, step});
          pos_y_n[i] = clamp_y(tgt);
        end
      end
`ifdef PADDLE_AI_EN
      speed_n[1] = SPD_MIN;
      count_n[1] = '0;
      last_n[1]  = DIR_NONE;
      if (ball_s > p2_s + AI_DB)      pos_y_n[1] = clamp_y(p2_s + AI_S);
      else if (ball_s < p2_s - AI_DB) pos_y_n[1] = clamp_y(p2_s - AI_S);
      else                            pos_y_n[1] = pos_y[1];
`endif
    end
  end

  assign Paddle1X   = 10'(P1_X);
  assign Paddle2X   = 10'(P2_X);
  assign Paddle1L   = 10'(HALF_LEN);
  assign Paddle2L   = 10'(HALF_LEN);
  assign Paddle1W   = 10'(HALF_W);
  assign Paddle2W   = 10'(HALF_W);
  assign Paddle1Y   = pos_y[0];
  assign Paddle2Y   = pos_y[1];
  assign paddleHold = (state == HOLD);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: directed scenarios plus randomized play against a frame-level model.
module tb_paddle_ctrl;
  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode0, keycode1;
  logic       nGame, eGame;
  logic [9:0] BallY;
  logic [9:0] Paddle1X, Paddle1Y, Paddle2X, Paddle2Y;
  logic [9:0] Paddle1L, Paddle1W, Paddle2L, Paddle2W;
  logic       paddleHold;

  int n_checks = 0;
  int n_fail   = 0;

  // frame-level model of the paddle rules
  bit play;
  int my[2], mspd[2], mcnt[2], mlast[2];
  logic [7:0] key_tab[6] = '{8'h00, 8'h1A, 8'h16, 8'h52, 8'h51, 8'h04};
  logic [7:0] up_code[2] = '{8'h1A, 8'h52};
  logic [7:0] dn_code[2] = '{8'h16, 8'h51};

  paddle_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode0(keycode0), .keycode1(keycode1),
    .nGame(nGame), .eGame(eGame), .BallY(BallY),
    .Paddle1X(Paddle1X), .Paddle1Y(Paddle1Y), .Paddle2X(Paddle2X), .Paddle2Y(Paddle2Y),
    .Paddle1L(Paddle1L), .Paddle1W(Paddle1W), .Paddle2L(Paddle2L), .Paddle2W(Paddle2W),
    .paddleHold(paddleHold)
  );

  always #5 frame_clk = ~frame_clk;

  function automatic int clampv(int v);
    if (v < 50) return 50;
    if (v > 431) return 431;
    return v;
  endfunction

  function automatic void model_reset();
    play = 1'b0;
    for (int p = 0; p < 2; p++) begin
      my[p] = 240; mspd[p] = 2; mcnt[p] = 0; mlast[p] = 0;
    end
  endfunction

  function automatic void model_step();
    bit u, d;
    int dirv, mv;
    if (!play || nGame || eGame) begin
      model_reset();
      play = !nGame && !eGame;
      return;
    end
    for (int p = 0; p < 2; p++) begin
      u = (keycode0 == up_code[p]) || (keycode1 == up_code[p]);
      d = (keycode0 == dn_code[p]) || (keycode1 == dn_code[p]);
      dirv = (u && !d) ? 1 : (d && !u) ? 2 : 0;
      if (dirv == 0) begin
        mspd[p] = 2; mcnt[p] = 0; mlast[p] = 0;
      end else begin
        if (dirv != mlast[p]) begin
          mv = 2; mspd[p] = 2; mcnt[p] = 1;
        end else begin
          mv = mspd[p];
          if (mcnt[p] == 3) begin
            mspd[p] = (mspd[p] + 1 > 8) ? 8 : mspd[p] + 1;
            mcnt[p] = 0;
          end else mcnt[p]++;
        end
        mlast[p] = dirv;
        my[p] = clampv(dirv == 1 ? my[p] - mv : my[p] + mv);
      end
    end
`ifdef PADDLE_AI_EN
    if (int'(BallY) > my[1] + 6)      my[1] = clampv(my[1] + 4);
    else if (int'(BallY) < my[1] - 6) my[1] = clampv(my[1] - 4);
`endif
  endfunction

  task automatic tick();
    @(posedge frame_clk);
    model_step();
    #1;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    #2;
    model_reset();
    Reset = 1'b0;
    #1;
  endtask

  task automatic start_play();
    nGame = 1'b0; eGame = 1'b0; keycode0 = 8'h00; keycode1 = 8'h00;
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #2;
    n_checks += 9;
    if (Paddle1X !== 10'd50)  begin n_fail++; $display("[TB] FAIL reset_p1x got %0d want 50", Paddle1X); end
    if (Paddle2X !== 10'd580) begin n_fail++; $display("[TB] FAIL reset_p2x got %0d want 580", Paddle2X); end
    if (Paddle1L !== 10'd30)  begin n_fail++; $display("[TB] FAIL reset_p1l got %0d want 30", Paddle1L); end
    if (Paddle2L !== 10'd30)  begin n_fail++; $display("[TB] FAIL reset_p2l got %0d want 30", Paddle2L); end
    if (Paddle1W !== 10'd4)   begin n_fail++; $display("[TB] FAIL reset_p1w got %0d want 4", Paddle1W); end
    if (Paddle2W !== 10'd4)   begin n_fail++; $display("[TB] FAIL reset_p2w got %0d want 4", Paddle2W); end
    if (Paddle1Y !== 10'd240) begin n_fail++; $display("[TB] FAIL reset_p1y got %0d want 240", Paddle1Y); end
    if (Paddle2Y !== 10'd240) begin n_fail++; $display("[TB] FAIL reset_p2y got %0d want 240", Paddle2Y); end
    if (paddleHold !== 1'b1)  begin n_fail++; $display("[TB] FAIL reset_hold got %0b want 1", paddleHold); end
    model_reset();
    Reset = 1'b0;
    #1;
  endtask

  task automatic test_start();
    nGame = 1'b1; keycode0 = 8'h1A;
    repeat (3) tick();
    n_checks += 2;
    if (paddleHold !== 1'b1)  begin n_fail++; $display("[TB] FAIL wait_hold got %0b want 1", paddleHold); end
    if (Paddle1Y !== 10'd240) begin n_fail++; $display("[TB] FAIL wait_p1y got %0d want 240", Paddle1Y); end
    start_play();
    n_checks += 2;
    if (paddleHold !== 1'b0)  begin n_fail++; $display("[TB] FAIL start_hold got %0b want 0", paddleHold); end
    if (Paddle1Y !== 10'd240) begin n_fail++; $display("[TB] FAIL start_p1y got %0d want 240", Paddle1Y); end
  endtask

  task automatic test_accel();
    int exp_y[5] = '{238, 236, 234, 232, 229};
    keycode0 = 8'h1A;
    for (int f = 0; f < 5; f++) begin
      tick();
      n_checks++;
      if (Paddle1Y !== 10'(exp_y[f])) begin
        n_fail++; $display("[TB] FAIL accel_f%0d got %0d want %0d", f, Paddle1Y, exp_y[f]);
      end
    end
    keycode0 = 8'h00;
    tick();
  endtask

  task automatic test_clamp_bottom();
    keycode1 = 8'h16;
    for (int f = 0; f < 200; f++) begin
      tick();
      n_checks++;
      if (Paddle1Y !== 10'(my[0])) begin
        n_fail++; $display("[TB] FAIL clamp_f%0d got %0d want %0d", f, Paddle1Y, my[0]);
      end
    end
    n_checks++;
    if (Paddle1Y !== 10'd431) begin n_fail++; $display("[TB] FAIL clamp_final got %0d want 431", Paddle1Y); end
    keycode1 = 8'h00;
    tick();
  endtask

  task automatic test_both_keys();
    logic [9:0] y0;
    y0 = Paddle1Y;
    keycode0 = 8'h1A; keycode1 = 8'h16;
    repeat (3) tick();
    n_checks++;
    if (Paddle1Y !== y0) begin n_fail++; $display("[TB] FAIL both_keys got %0d want %0d", Paddle1Y, y0); end
    keycode0 = 8'h00; keycode1 = 8'h16;
    tick();
    n_checks++;
    if (Paddle1Y !== 10'(clampv(int'(y0) + 2))) begin
      n_fail++; $display("[TB] FAIL s_after_both got %0d want %0d", Paddle1Y, clampv(int'(y0) + 2));
    end
    keycode1 = 8'h00;
    tick();
  endtask

  task automatic test_game_over();
    pulse_reset();
    start_play();
    keycode0 = 8'h16;
    repeat (12) tick();
    n_checks++;
    if (Paddle1Y !== 10'(my[0]) || my[0] == 240) begin
      n_fail++; $display("[TB] FAIL pre_over_p1y got %0d want %0d", Paddle1Y, my[0]);
    end
    eGame = 1'b1;
    tick();
    n_checks += 2;
    if (Paddle1Y !== 10'd240) begin n_fail++; $display("[TB] FAIL over_p1y got %0d want 240", Paddle1Y); end
    if (paddleHold !== 1'b1)  begin n_fail++; $display("[TB] FAIL over_hold got %0b want 1", paddleHold); end
    eGame = 1'b0; keycode0 = 8'h00;
    tick();
  endtask

  task automatic test_reset_mid_motion();
    start_play();
    keycode0 = 8'h52; keycode1 = 8'h1A;
    repeat (9) tick();
    Reset = 1'b1;
    #2;
    n_checks += 3;
    if (Paddle1Y !== 10'd240) begin n_fail++; $display("[TB] FAIL midrst_p1y got %0d want 240", Paddle1Y); end
    if (Paddle2Y !== 10'd240) begin n_fail++; $display("[TB] FAIL midrst_p2y got %0d want 240", Paddle2Y); end
    if (paddleHold !== 1'b1)  begin n_fail++; $display("[TB] FAIL midrst_hold got %0b want 1", paddleHold); end
    model_reset();
    Reset = 1'b0;
    #1;
    tick();
    tick();
    n_checks++;
    if (Paddle1Y !== 10'd238) begin n_fail++; $display("[TB] FAIL midrst_speed got %0d want 238", Paddle1Y); end
    keycode0 = 8'h00; keycode1 = 8'h00;
  endtask

  task automatic test_random();
    for (int f = 0; f < 1500; f++) begin
      if ($urandom_range(5) == 0) keycode0 = key_tab[$urandom_range(5)];
      if ($urandom_range(5) == 0) keycode1 = key_tab[$urandom_range(5)];
      eGame = ($urandom_range(80) == 0);
      nGame = ($urandom_range(120) == 0);
      if ($urandom_range(7) == 0) BallY = 10'($urandom_range(479));
      tick();
      n_checks++;
      if (Paddle1Y !== 10'(my[0]) || Paddle2Y !== 10'(my[1]) || paddleHold !== !play) begin
        n_fail++;
        $display("[TB] FAIL random_f%0d got y1=%0d y2=%0d hold=%0b want y1=%0d y2=%0d hold=%0b",
                 f, Paddle1Y, Paddle2Y, paddleHold, my[0], my[1], !play);
      end
    end
    eGame = 1'b0; nGame = 1'b0; keycode0 = 8'h00; keycode1 = 8'h00;
  endtask

`ifdef PADDLE_AI_EN
  task automatic test_ai();
    pulse_reset();
    BallY = 10'd300;
    start_play();
    keycode0 = 8'h52;
    for (int f = 1; f <= 17; f++) begin
      tick();
      n_checks++;
      if (Paddle2Y !== 10'((f <= 14) ? 240 + 4 * f : 296)) begin
        n_fail++; $display("[TB] FAIL ai_f%0d got %0d want %0d", f, Paddle2Y, (f <= 14) ? 240 + 4 * f : 296);
      end
    end
    keycode0 = 8'h00;
  endtask
`endif

  initial begin
    keycode0 = 8'h00; keycode1 = 8'h00; nGame = 1'b1; eGame = 1'b0; BallY = 10'd240;
    Reset = 1'b0;
    model_reset();
    test_reset();
    test_start();
    test_accel();
    test_clamp_bottom();
    test_both_keys();
    test_game_over();
    test_reset_mid_motion();
`ifdef PADDLE_AI_EN
    test_ai();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
